// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle RV32I control FSM with memory wait states, bus timeout and sticky trap
module mc_controller #(
  parameter int MEM_WAIT = 1,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        adr_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_control,
  output logic        trap,
  output logic [3:0]  state_o
);

  localparam logic [3:0] ALU_ADD              = 4'd0;
  localparam logic [3:0] ALU_SUB              = 4'd1;
  localparam logic [3:0] ALU_SHIFTL           = 4'd2;
  localparam logic [3:0] ALU_LESS_THAN_SIGNED = 4'd3;
  localparam logic [3:0] ALU_LESS_THAN        = 4'd4;
  localparam logic [3:0] ALU_XOR              = 4'd5;
  localparam logic [3:0] ALU_SHIFTR           = 4'd6;
  localparam logic [3:0] ALU_SHIFTR_ARITH     = 4'd7;
  localparam logic [3:0] ALU_OR               = 4'd8;
  localparam logic [3:0] ALU_AND              = 4'd9;

  localparam logic [2:0] EXT_IMM_I = 3'd0;
  localparam logic [2:0] EXT_IMM_S = 3'd1;
  localparam logic [2:0] EXT_IMM_B = 3'd2;
  localparam logic [2:0] EXT_IMM_U = 3'd3;
  localparam logic [2:0] EXT_IMM_J = 3'd4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam bit TO_EN = (MEM_WAIT != 0) && (TIMEOUT > 0);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC_R   = 4'd7,
    S_EXEC_I   = 4'd8,
    S_ALUWB    = 4'd9,
    S_JAL      = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             rdy;
  logic             in_mem;
  logic             timeout_hit;
  logic             taken;
  logic             branch_bad;
  logic [2:0]       imm_sel;
  logic             unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  assign state_o      = state;

  assign rdy         = (MEM_WAIT == 0) || mem_ready;
  assign in_mem      = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout_hit = TO_EN && in_mem && !rdy && (wait_cnt == CNT_W'(TIMEOUT - 1));

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SHIFTL;
      3'b010:  alu_op = ALU_LESS_THAN_SIGNED;
      3'b011:  alu_op = ALU_LESS_THAN;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SHIFTR_ARITH : ALU_SHIFTR;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    imm_sel = EXT_IMM_I;
    case (opcode)
      OPC_STORE:  imm_sel = EXT_IMM_S;
      OPC_BRANCH: imm_sel = EXT_IMM_B;
      OPC_LUI:    imm_sel = EXT_IMM_U;
      OPC_JAL:    imm_sel = EXT_IMM_J;
      default:    imm_sel = EXT_IMM_I;
    endcase
  end

  // funct3 010/011 are not branches; they fall through to TRAP
  always_comb begin
    taken      = 1'b0;
    branch_bad = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: branch_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (TO_EN && in_mem && !rdy) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next  = state;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 3'd0;
    alu_control = ALU_ADD;
    trap        = 1'b0;

    if (state != S_IDLE && state != S_TRAP) begin
      imm_src = imm_sel;
    end

    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = rdy;
        pc_write   = rdy;
        if (rdy) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OPC_LOAD, OPC_STORE: state_next = S_MEMADR;
          OPC_OP:              state_next = S_EXEC_R;
          OPC_OP_IMM:          state_next = S_EXEC_I;
          OPC_JAL:             state_next = S_JAL;
          OPC_BRANCH:          state_next = S_BRANCH;
          OPC_LUI:             state_next = S_LUI;
          default:             state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (rdy) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (rdy) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = alu_op(funct3, instr[30]);
        state_next  = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_op(funct3, (funct3 == 3'b101) && instr[30]);
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = ALU_SUB;
        pc_write    = taken;
        state_next  = branch_bad ? S_TRAP : S_FETCH;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        state_next = S_ALUWB;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase

    if (timeout_hit) state_next = S_TRAP;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle RISC-V RV32I control unit that succeeds the single-cycle decoder.
- An FSM sequences fetch, decode, execute, memory and writeback over a shared memory port and a shared ALU.
- It adds a memory wait-state handshake, a bus timeout and the full branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- It has a sticky trap for illegal encodings.
- It sits between the instruction register, the datapath muxes and the ALU. ALU and immediate encodings are the `ALU_*`/`Ext_Imm*` codes from define.v.

Parameters:
- MEM_WAIT, 1, 1: FETCH/MEMREAD/MEMWRITE hold until mem_ready=1. 0: mem_ready is ignored and treated as 1.
- TIMEOUT, 16: consecutive mem_ready=0 wait cycles in one memory state that trigger TRAP. 0 disables the timeout. Only meaningful when MEM_WAIT=1.
- CNT_W, 5: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction register output, stable from DECODE onward.
- zero  in  1  ALU result==0.
- lt  in  1  signed rs1<rs2 from the ALU comparator.
- ltu  in  1  unsigned rs1<rs2.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR and oldPC load enable.
- adr_src  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux: 00=ALUOut, 01=mem data, 10=ALU result.
- alu_src_a  out  2  ALU A: 00=PC, 01=oldPC, 10=rs1, 11=zero.
- alu_src_b  out  2  ALU B: 00=rs2, 01=imm, 10=4.
- imm_src  out  3  `Ext_Imm*` selected by opcode.
- alu_control  out  4  `ALU_*` code.
- trap  out  1  sticky fault flag.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timeout counter=0. In IDLE every output is 0 and alu_control=`ALU_ADD`. IDLE→FETCH unconditionally on the first clk after rst_n rises.
- Outputs are Moore: combinational from state, plus instr fields where listed. Every enable not listed for a state is 0.
- FETCH: mem_read=1, adr_src=0, A=PC, B=4, ADD, result_src=10. ir_write=pc_write=mem_ready. Moves to DECODE when mem_ready.
- DECODE: A=oldPC, B=imm, ADD (branch/JAL target into ALUOut). imm_src from opcode. Next state by opcode:
  - LOAD/STORE→MEMADR
  - OP→EXEC_R
  - OP-IMM→EXEC_I
  - JAL→JAL
  - BRANCH→BRANCH
  - LUI→LUI
  - any other opcode→TRAP
- MEMADR: A=rs1, B=imm, ADD. LOAD→MEMREAD, STORE→MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1. Moves to MEMWB when mem_ready, otherwise holds.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWRITE: adr_src=1, mem_write=1, held stable while waiting. Moves to FETCH when mem_ready.
- EXEC_R: A=rs1, B=rs2. alu_control from funct3/funct7[5]:
  - 000: ADD, or SUB if f7[5]=1
  - 001: SHIFTL
  - 010: LESS_THAN_SIGNED
  - 011: LESS_THAN
  - 100: XOR
  - 101: SHIFTR, or SHIFTR_ARITH if f7[5]=1
  - 110: OR
  - 111: AND
  - Other funct7 bits are ignored.
  - Next state ALUWB.
- EXEC_I: A=rs1, B=imm, same mapping as EXEC_R except funct3=000 is always ADD. SRAI is selected by instr[30]. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- JAL: A=oldPC, B=4, ADD, result_src=00, pc_write=1 (PC←target). Next state ALUWB (rd←oldPC+4).
- BRANCH: A=rs1, B=rs2, SUB, result_src=00. pc_write=taken, where taken is:
  - BEQ: zero
  - BNE: !zero
  - BLT: lt
  - BGE: !lt
  - BLTU: ltu
  - BGEU: !ltu
  - Next state FETCH. funct3 010/011 go to TRAP instead, with pc_write=0.
- LUI: A=zero, B=imm (`Ext_ImmU`), ADD. Next state ALUWB.
- TRAP: trap=1, all enables 0. Sticky; only rst_n exits.
- Timeout (MEM_WAIT=1, TIMEOUT>0):
  - The counter increments each cycle spent in FETCH/MEMREAD/MEMWRITE with mem_ready=0.
  - It clears on any state change.
  - When count==TIMEOUT-1 and mem_ready=0, the next state is TRAP.
  - mem_ready=1 in that same cycle wins: normal transition, no trap.
- Latency with mem_ready=1 throughout (cycles from FETCH to the next FETCH):
  - R/I/LUI/JAL: 4
  - load: 5
  - store: 4
  - branch: 3
- Reset mid-operation: async return to IDLE, with any pending mem_write/reg_write deasserted immediately.

Test Plan:
1. Reset, then ADD x3,x1,x2 with MEM_WAIT=1, mem_ready=1 → states IDLE,FETCH,DECODE,EXEC_R,ALUWB,FETCH. reg_write=1 only in ALUWB. alu_control=`ALU_ADD`. With funct7=0100000 → `ALU_SUB`.
2. LW, mem_ready held 0 for 3 cycles in MEMREAD → mem_read/adr_src stable for 4 cycles, no trap, MEMWB reg_write with result_src=01. SW with the same stall → mem_write held 4 cycles, reg_write never 1.
3. Branches with zero/lt/ltu swept:
   - BNE with zero=0 → pc_write=1.
   - BGE with lt=1 → pc_write=0.
   - BLTU with ltu=1 → pc_write=1.
   - funct3=010 → TRAP, trap=1.
4. TIMEOUT=16, mem_ready=0 in FETCH → trap=1 exactly 16 cycles after entering FETCH.
   - mem_ready=1 on the 16th wait cycle → DECODE, no trap.
5. Opcode 1111111 → TRAP from DECODE, all enables 0, trap held for 10 cycles.
   - rst_n low for one cycle asynchronously clears trap, state_o=IDLE.
6. MEM_WAIT=0 with mem_ready tied 0 → JAL completes in 4 cycles: pc_write in FETCH and JAL, reg_write in ALUWB, no trap.
